// File: rtl/asi_arb.sv
// N-channel burst arbiter sharing one user-side memory port; grant is registered, usr_ce is combinational.
// Fixed-priority or round-robin selection, optional beat quota yield, read return tagged after SLV_WS cycles.
module asi_arb #(
  parameter int N_CH       = 4,
  parameter int AXI_AW     = 40,
  parameter int AXI_DW     = 128,
  parameter int AXI_WSTRBW = AXI_DW / 8,
  parameter int ARB_MODE   = 1,
  parameter int QUOTA      = 0,
  parameter int SLV_WS     = 1,
  parameter int CHW        = $clog2(N_CH)
) (
  input  logic                         usr_clk,
  input  logic                         usr_reset_n,
  input  logic [N_CH-1:0]              req,
  input  logic [N_CH-1:0]              ce,
  input  logic [N_CH-1:0]              last,
  input  logic [N_CH*AXI_AW-1:0]       a,
  input  logic [N_CH*AXI_DW-1:0]       d,
  input  logic [N_CH*AXI_WSTRBW-1:0]   we,
  output logic [N_CH-1:0]              gnt,
  output logic [CHW-1:0]               owner,
  output logic [AXI_AW-1:0]            usr_a,
  output logic                         usr_ce,
  output logic [AXI_DW-1:0]            usr_d,
  output logic [AXI_WSTRBW-1:0]        usr_we,
  input  logic [AXI_DW-1:0]            usr_q,
  output logic [N_CH-1:0]              rvalid,
  output logic [AXI_DW-1:0]            rdata
);

  localparam int CNTW = (QUOTA > 1) ? $clog2(QUOTA) : 1;
  localparam logic [CNTW-1:0] QLIM = CNTW'((QUOTA > 0) ? QUOTA - 1 : 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [N_CH-1:0]             gnt_q, gnt_d;
  logic [CHW-1:0]              owner_q, owner_d;
  logic [CHW-1:0]              ptr_q, ptr_d;
  logic [CNTW-1:0]             cnt_q, cnt_d;
  logic [SLV_WS-1:0]           rv_q, rv_d;
  logic [SLV_WS-1:0][CHW-1:0]  rid_q, rid_d;

  logic [N_CH-1:0]             oth_req;
  logic [CHW:0]                pick_all;
  logic [CHW:0]                pick_oth;
  logic                        accept;
  logic                        is_last;
  logic                        quota_hit;
  logic                        rel;
  logic                        rd_push;

  // Returns {found, index}; round-robin treats the pointer's own channel as lowest priority.
  function automatic logic [CHW:0] pick(input logic [N_CH-1:0] m, input logic [CHW-1:0] p);
    logic [CHW:0] r;
    int unsigned  j;
    r = '0;
    for (int k = N_CH; k >= 1; k--) begin
      if (ARB_MODE == 0) begin
        j = k - 1;
      end else begin
        j = (int'(p) + k) % N_CH;
      end
      if (m[j]) begin
        r = {1'b1, CHW'(j)};
      end
    end
    return r;
  endfunction

  assign oth_req   = req & ~gnt_q;
  assign pick_all  = pick(req, ptr_q);
  assign pick_oth  = pick(oth_req, ptr_q);
  assign accept    = usr_ce;
  assign is_last   = last[owner_q];
  assign quota_hit = (QUOTA > 0) && accept && !is_last && (|oth_req) && (cnt_q == QLIM);
  assign rel       = accept && (is_last || quota_hit);
  assign rd_push   = accept && (usr_we == '0);

  // State register
  always_ff @(posedge usr_clk) begin
    if (!usr_reset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= CHW'(N_CH - 1);
      cnt_q   <= '0;
      rv_q    <= '0;
      rid_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_all[CHW]) begin
          state_d                  = ST_BUSY;
          gnt_d                    = '0;
          gnt_d[pick_all[CHW-1:0]] = 1'b1;
          owner_d                  = pick_all[CHW-1:0];
          ptr_d                    = pick_all[CHW-1:0];
          cnt_d                    = '0;
        end
      end
      ST_BUSY: begin
        if (rel) begin
          cnt_d = '0;
          if (pick_oth[CHW]) begin
            gnt_d                    = '0;
            gnt_d[pick_oth[CHW-1:0]] = 1'b1;
            owner_d                  = pick_oth[CHW-1:0];
            ptr_d                    = pick_oth[CHW-1:0];
          end else if (quota_hit && req[owner_q]) begin
            ptr_d = owner_q;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    // Read tags ride a fixed-length shift register, independent of grant changes.
    rv_d     = rv_q;
    rid_d    = rid_q;
    rv_d[0]  = rd_push;
    rid_d[0] = owner_q;
    for (int s = 1; s < SLV_WS; s++) begin
      rv_d[s]  = rv_q[s-1];
      rid_d[s] = rid_q[s-1];
    end
  end

  // Output logic
  always_comb begin
    gnt    = gnt_q;
    owner  = owner_q;
    usr_ce = |(gnt_q & ce);
    usr_a  = a[int'(owner_q)*AXI_AW +: AXI_AW];
    usr_d  = d[int'(owner_q)*AXI_DW +: AXI_DW];
    usr_we = usr_ce ? we[int'(owner_q)*AXI_WSTRBW +: AXI_WSTRBW] : '0;
    rdata  = usr_q;
    rvalid = '0;
    if (rv_q[SLV_WS-1]) begin
      rvalid[rid_q[SLV_WS-1]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_asi_arb.sv
// Directed bench for asi_arb: round-robin/quota/read-latency instance and a fixed-priority instance.
module tb_asi_arb;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int WS = 4;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req, ce, last;
  logic [N*AW-1:0]   a;
  logic [N*DW-1:0]   d;
  logic [N*WS-1:0]   we;
  logic [DW-1:0]     usr_q;

  logic [N-1:0]      gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [1:0]        owner_a, owner_b;
  logic [AW-1:0]     usr_a_a, usr_a_b;
  logic              usr_ce_a, usr_ce_b;
  logic [DW-1:0]     usr_d_a, usr_d_b, rdata_a, rdata_b;
  logic [WS-1:0]     usr_we_a, usr_we_b;

  asi_arb #(.N_CH(N), .AXI_AW(AW), .AXI_DW(DW), .AXI_WSTRBW(WS),
            .ARB_MODE(1), .QUOTA(4), .SLV_WS(3)) u_a (
    .usr_clk(clk), .usr_reset_n(rst_n), .req(req), .ce(ce), .last(last),
    .a(a), .d(d), .we(we), .gnt(gnt_a), .owner(owner_a), .usr_a(usr_a_a),
    .usr_ce(usr_ce_a), .usr_d(usr_d_a), .usr_we(usr_we_a), .usr_q(usr_q),
    .rvalid(rvalid_a), .rdata(rdata_a));

  asi_arb #(.N_CH(N), .AXI_AW(AW), .AXI_DW(DW), .AXI_WSTRBW(WS),
            .ARB_MODE(0), .QUOTA(0), .SLV_WS(1)) u_b (
    .usr_clk(clk), .usr_reset_n(rst_n), .req(req), .ce(ce), .last(last),
    .a(a), .d(d), .we(we), .gnt(gnt_b), .owner(owner_b), .usr_a(usr_a_b),
    .usr_ce(usr_ce_b), .usr_d(usr_d_b), .usr_we(usr_we_b), .usr_q(usr_q),
    .rvalid(rvalid_b), .rdata(rdata_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         rst;
    bit         sel;    // 0 = u_a, 1 = u_b
    logic [3:0] req;
    logic [3:0] ce;
    logic [3:0] last;
    logic [3:0] wr;
    bit         chk;
    logic [3:0] gnt;
    logic [1:0] owner;
    bit         uce;
    logic [3:0] rv;
  } vec_t;

  vec_t tv[64];
  int   nv = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic add(input bit rs, input bit sl, input logic [3:0] rq, input logic [3:0] c,
                     input logic [3:0] l, input logic [3:0] w, input bit ck, input logic [3:0] g,
                     input logic [1:0] o, input bit u, input logic [3:0] rv);
    tv[nv] = '{rs, sl, rq, c, l, w, ck, g, o, u, rv};
    nv++;
  endtask

  task automatic check(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req = '0; ce = '0; last = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0]  g, rv, ew;
    logic [1:0]  o;
    logic        u;
    logic [15:0] ua;
    logic [31:0] ud, rd;
    int          b0, b2, n_before;
    bit          done;

    rst_n = 1'b0; req = '0; ce = '0; last = '0; we = '0; usr_q = '0;
    a = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    d = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

    // rst sel req    ce     last   wr     chk gnt    own uce rvalid
    add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0);
    add(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 4'h0);
    add(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 4'h0);
    // Round-robin, all requesting, 2-beat write bursts
    add(0, 0, 4'hF, 4'h0, 4'h0, 4'hF, 1, 4'h0, 0, 0, 4'h0);
    add(0, 0, 4'hF, 4'h1, 4'h0, 4'hF, 1, 4'h1, 0, 1, 4'h0);
    add(0, 0, 4'hF, 4'h1, 4'h1, 4'hF, 1, 4'h1, 0, 1, 4'h0);
    add(0, 0, 4'hF, 4'h2, 4'h0, 4'hF, 1, 4'h2, 1, 1, 4'h0);
    add(0, 0, 4'hF, 4'h2, 4'h2, 4'hF, 1, 4'h2, 1, 1, 4'h0);
    add(0, 0, 4'hF, 4'h4, 4'h0, 4'hF, 1, 4'h4, 2, 1, 4'h0);
    add(0, 0, 4'hF, 4'h4, 4'h4, 4'hF, 1, 4'h4, 2, 1, 4'h0);
    add(0, 0, 4'hF, 4'h8, 4'h0, 4'hF, 1, 4'h8, 3, 1, 4'h0);
    add(0, 0, 4'hF, 4'h8, 4'h8, 4'hF, 1, 4'h8, 3, 1, 4'h0);
    add(0, 0, 4'hF, 4'h1, 4'h0, 4'hF, 1, 4'h1, 0, 1, 4'h0);
    add(0, 0, 4'h1, 4'h1, 4'h1, 4'hF, 1, 4'h1, 0, 1, 4'h0);
    add(0, 0, 4'h0, 4'h0, 4'h0, 4'hF, 1, 4'h0, 0, 0, 4'h0);
    // Fixed priority: channel 1 holds, channel 3 pulses are ignored
    add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0);
    add(0, 1, 4'hA, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 4'h0);
    add(0, 1, 4'hA, 4'h2, 4'h0, 4'h0, 1, 4'h2, 1, 1, 4'h0);
    add(0, 1, 4'hA, 4'hA, 4'h8, 4'h8, 1, 4'h2, 1, 1, 4'h2);
    add(0, 1, 4'hA, 4'h0, 4'h0, 4'h0, 1, 4'h2, 1, 0, 4'h2);
    add(0, 1, 4'hA, 4'h8, 4'h8, 4'h0, 1, 4'h2, 1, 0, 4'h0);
    add(0, 1, 4'hA, 4'h2, 4'h2, 4'h0, 1, 4'h2, 1, 1, 4'h0);
    add(0, 1, 4'h8, 4'h0, 4'h0, 4'h0, 1, 4'h8, 3, 0, 4'h2);
    add(0, 1, 4'h8, 4'h8, 4'h8, 4'h8, 1, 4'h8, 3, 1, 4'h0);
    add(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 3, 0, 4'h0);
    // Read return with SLV_WS=3: ch2 reads x3, ch1 read then write
    add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0);
    add(0, 0, 4'h4, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 4'h0);
    add(0, 0, 4'h6, 4'h4, 4'h0, 4'h0, 1, 4'h4, 2, 1, 4'h0);
    add(0, 0, 4'h6, 4'h4, 4'h0, 4'h0, 1, 4'h4, 2, 1, 4'h0);
    add(0, 0, 4'h6, 4'h4, 4'h4, 4'h0, 1, 4'h4, 2, 1, 4'h0);
    add(0, 0, 4'h2, 4'h2, 4'h0, 4'h0, 1, 4'h2, 1, 1, 4'h4);
    add(0, 0, 4'h2, 4'h2, 4'h2, 4'h2, 1, 4'h2, 1, 1, 4'h4);
    add(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 1, 0, 4'h4);
    add(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 1, 0, 4'h2);
    add(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 1, 0, 4'h0);
    add(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 1, 0, 4'h0);
    // Reset mid-burst with a read in flight; pointer returns to N_CH-1
    add(0, 0, 4'h4, 4'h0, 4'h0, 4'h0, 1, 4'h0, 1, 0, 4'h0);
    add(0, 0, 4'h4, 4'h4, 4'h0, 4'h0, 1, 4'h4, 2, 1, 4'h0);
    add(1, 0, 4'h4, 4'h4, 4'h0, 4'h0, 1, 4'h4, 2, 1, 4'h0);
    add(0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 4'h0);
    add(0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h1, 0, 0, 4'h0);
    add(0, 0, 4'hF, 4'h1, 4'h1, 4'hF, 1, 4'h1, 0, 1, 4'h0);

    for (int i = 0; i < nv; i++) begin
      @(posedge clk); #1;
      rst_n = !tv[i].rst;
      req   = tv[i].req;
      ce    = tv[i].ce;
      last  = tv[i].last;
      for (int c = 0; c < N; c++) we[c*WS +: WS] = tv[i].wr[c] ? 4'hF : 4'h0;
      usr_q = 32'h5A00_0000 + 32'(i);
      @(negedge clk);
      if (tv[i].chk) begin
        g  = tv[i].sel ? gnt_b    : gnt_a;
        o  = tv[i].sel ? owner_b  : owner_a;
        u  = tv[i].sel ? usr_ce_b : usr_ce_a;
        rv = tv[i].sel ? rvalid_b : rvalid_a;
        ua = tv[i].sel ? usr_a_b  : usr_a_a;
        ud = tv[i].sel ? usr_d_b  : usr_d_a;
        ew = tv[i].sel ? usr_we_b : usr_we_a;
        rd = tv[i].sel ? rdata_b  : rdata_a;
        check("gnt", i, 32'(g), 32'(tv[i].gnt));
        check("owner", i, 32'(o), 32'(tv[i].owner));
        check("usr_ce", i, 32'(u), 32'(tv[i].uce));
        check("rvalid", i, 32'(rv), 32'(tv[i].rv));
        check("usr_a", i, 32'(ua), 32'(16'hA000 + 16'(tv[i].owner)));
        check("usr_d", i, ud, 32'hD000_0000 + 32'(tv[i].owner));
        check("usr_we", i, 32'(ew), (tv[i].uce && tv[i].wr[tv[i].owner]) ? 32'hF : 32'h0);
        check("rdata", i, rd, 32'h5A00_0000 + 32'(i));
      end
    end

    // Quota: ch0 10-beat write burst yields after beat 4 to ch2's 2-beat burst
    do_reset();
    we = '1;
    b0 = 0; b2 = 0; n_before = -1; done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(posedge clk); #1;
      req  = '0; ce = '0; last = '0;
      req[0] = (b0 < 10);
      req[2] = (b2 < 2);
      a[15:0]  = 16'h0100 + 16'(b0);
      a[47:32] = 16'h0200 + 16'(b2);
      if (gnt_a[0] && b0 < 10) begin ce[0] = 1'b1; last[0] = (b0 == 9); end
      if (gnt_a[2] && b2 < 2)  begin ce[2] = 1'b1; last[2] = (b2 == 1); end
      @(negedge clk);
      if (usr_ce_a) begin
        if (owner_a == 2'd0) begin
          check("quota_addr_ch0", b0, 32'(usr_a_a), 32'(16'h0100 + 16'(b0)));
          b0++;
        end else if (owner_a == 2'd2) begin
          check("quota_addr_ch2", b2, 32'(usr_a_a), 32'(16'h0200 + 16'(b2)));
          if (b2 == 0) n_before = b0;
          b2++;
        end else begin
          check("quota_owner", cyc, 32'(owner_a), 32'h0);
        end
      end
      done = (b0 == 10) && (b2 == 2);
    end
    check("quota_done", 0, 32'(done), 32'h1);
    check("quota_beats_ch0", 0, 32'(b0), 32'd10);
    check("quota_beats_ch2", 0, 32'(b2), 32'd2);
    check("quota_yield_point", 0, 32'(n_before), 32'd4);
    @(posedge clk); #1;
    req = '0; ce = '0; last = '0;
    @(negedge clk);
    check("quota_idle_gnt", 0, 32'(gnt_a), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
